// File: rtl/instr_sequencer.sv
// instr_sequencer: hardwired fetch/decode/execute control unit for the DataPath.
// One micro-step per clock; memory steps stall on mem_ready with a bounded wait.
module instr_sequencer #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    output logic              PCout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              MARin,
    output logic              Zlowin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              IncPC,
    output logic              Read,
    output logic              Write,
    output logic              MD_read,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              Csignout,
    output logic              ADD,
    output logic              SUB,
    output logic              AND,
    output logic              OR,
    output logic              run,
    output logic              illegal_op,
    output logic              mem_err,
    output logic [4:0]        state_o
);

    localparam logic [4:0] ST_T0   = 5'd0;
    localparam logic [4:0] ST_T1   = 5'd1;
    localparam logic [4:0] ST_T2   = 5'd2;
    localparam logic [4:0] ST_T3   = 5'd3;
    localparam logic [4:0] ST_T4   = 5'd4;
    localparam logic [4:0] ST_T5   = 5'd5;
    localparam logic [4:0] ST_T6   = 5'd6;
    localparam logic [4:0] ST_T7   = 5'd7;
    localparam logic [4:0] ST_HALT = 5'd31;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    // Last stall cycle before the counter would reach MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [4:0]       state_r;
    logic [4:0]       next_state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;
    logic             mem_err_r;
    logic             err_set_s;

    logic [4:0] opcode_s;
    logic       is_reg_alu_s, is_imm_alu_s, is_ldi_s, is_ld_s, is_st_s;
    logic       is_nop_s, is_halt_s, is_legal_s, in_mem_step_s;
    logic       op_add_s, op_sub_s, op_and_s, op_or_s;
    logic       ir_unused_s;

    assign opcode_s    = ir[DATA_W-1 -: 5];
    assign ir_unused_s = ^ir[DATA_W-6:0];

    // Opcode classification; ir stays stable from T3 to the end of the instruction.
    always_comb begin
        is_reg_alu_s = (opcode_s == OP_ADD) || (opcode_s == OP_SUB) ||
                       (opcode_s == OP_AND) || (opcode_s == OP_OR);
        is_imm_alu_s = (opcode_s == OP_ADDI) || (opcode_s == OP_ANDI) ||
                       (opcode_s == OP_ORI);
        is_ldi_s     = (opcode_s == OP_LDI);
        is_ld_s      = (opcode_s == OP_LD);
        is_st_s      = (opcode_s == OP_ST);
        is_nop_s     = (opcode_s == OP_NOP);
        is_halt_s    = (opcode_s == OP_HALT);
        is_legal_s   = is_reg_alu_s || is_imm_alu_s || is_ldi_s || is_ld_s ||
                       is_st_s || is_nop_s || is_halt_s;
        op_add_s     = (opcode_s == OP_ADD) || (opcode_s == OP_ADDI) ||
                       is_ldi_s || is_ld_s || is_st_s;
        op_sub_s     = (opcode_s == OP_SUB);
        op_and_s     = (opcode_s == OP_AND) || (opcode_s == OP_ANDI);
        op_or_s      = (opcode_s == OP_OR)  || (opcode_s == OP_ORI);
    end

    assign in_mem_step_s = (state_r == ST_T1) ||
                           ((state_r == ST_T6) && is_ld_s) ||
                           ((state_r == ST_T7) && is_st_s);

    // Next-state and stall-counter logic; a stalled memory step overrides the step advance.
    always_comb begin
        next_state_s    = state_r;
        wait_cnt_next_s = '0;
        err_set_s       = 1'b0;
        case (state_r)
            ST_T0:   next_state_s = ST_T1;
            ST_T1:   next_state_s = ST_T2;
            ST_T2:   next_state_s = ST_T3;
            ST_T3: begin
                if (is_halt_s) begin
                    next_state_s = ST_HALT;
                end else if (is_reg_alu_s || is_imm_alu_s || is_ldi_s || is_ld_s || is_st_s) begin
                    next_state_s = ST_T4;
                end else begin
                    next_state_s = ST_T0;
                end
            end
            ST_T4:   next_state_s = ST_T5;
            ST_T5:   next_state_s = (is_ld_s || is_st_s) ? ST_T6 : ST_T0;
            ST_T6:   next_state_s = ST_T7;
            ST_T7:   next_state_s = ST_T0;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_T0;
        endcase
        if (in_mem_step_s && !mem_ready) begin
            if (wait_cnt_r == CNT_LAST) begin
                next_state_s = ST_HALT;
                err_set_s    = 1'b1;
            end else begin
                next_state_s    = state_r;
                wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
            end
        end else begin
            wait_cnt_next_s = '0;
        end
    end

    // State, stall counter and sticky error registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r    <= ST_T0;
            wait_cnt_r <= '0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
            mem_err_r  <= mem_err_r | err_set_s;
        end
    end

    // Moore decode of the registered step into DataPath strobes.
    always_comb begin
        {PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC} = 10'b0;
        {Read, Write, MD_read} = 3'b0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Csignout} = 7'b0;
        {ADD, SUB, AND, OR} = 4'b0;
        case (state_r)
            ST_T0: {PCout, MARin, IncPC, Zlowin} = 4'b1111;
            ST_T1: {Zlowout, PCin, Read, MD_read, MDRin} = 5'b11111;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
                if (is_reg_alu_s || is_imm_alu_s) begin
                    {Grb, Rout, Yin} = 3'b111;
                end else if (is_ldi_s || is_ld_s || is_st_s) begin
                    {Grb, BAout, Yin} = 3'b111;
                end else begin
                    Grb = 1'b0;
                end
            end
            ST_T4: begin
                if (is_reg_alu_s) begin
                    {Grc, Rout} = 2'b11;
                end else begin
                    Csignout = 1'b1;
                end
                Zlowin = 1'b1;
                {ADD, SUB, AND, OR} = {op_add_s, op_sub_s, op_and_s, op_or_s};
            end
            ST_T5: begin
                if (is_ld_s || is_st_s) begin
                    {Zlowout, MARin} = 2'b11;
                end else begin
                    {Zlowout, Gra, Rin} = 3'b111;
                end
            end
            ST_T6: begin
                if (is_ld_s) begin
                    {Read, MD_read, MDRin} = 3'b111;
                end else begin
                    {Gra, Rout, MDRin} = 3'b111;
                end
            end
            ST_T7: begin
                if (is_ld_s) begin
                    {MDRout, Gra, Rin} = 3'b111;
                end else begin
                    Write = 1'b1;
                end
            end
            default: Gra = 1'b0;
        endcase
    end

    assign run        = (state_r != ST_HALT);
    assign illegal_op = (state_r == ST_T3) && !is_legal_s;
    assign mem_err    = mem_err_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC;
    logic Read, Write, MD_read, Gra, Grb, Grc, Rin, Rout, BAout, Csignout;
    logic ADD, SUB, AND, OR, run, illegal_op, mem_err;
    logic [4:0] state_o;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] T0 = 5'd0, T1 = 5'd1, T2 = 5'd2, T3 = 5'd3,
                           T4 = 5'd4, T5 = 5'd5, T6 = 5'd6, T7 = 5'd7, HALT = 5'd31;

    // Strobe bit positions in the packed vector below.
    localparam logic [23:0] B_PCOUT = 24'h800000, B_ZLOWOUT = 24'h400000, B_MDROUT = 24'h200000,
                            B_MARIN = 24'h100000, B_ZLOWIN  = 24'h080000, B_PCIN   = 24'h040000,
                            B_MDRIN = 24'h020000, B_IRIN    = 24'h010000, B_YIN    = 24'h008000,
                            B_INCPC = 24'h004000, B_READ    = 24'h002000, B_WRITE  = 24'h001000,
                            B_MDREAD= 24'h000800, B_GRA     = 24'h000400, B_GRB    = 24'h000200,
                            B_GRC   = 24'h000100, B_RIN     = 24'h000080, B_ROUT   = 24'h000040,
                            B_BAOUT = 24'h000020, B_CSIGN   = 24'h000010, B_ADD    = 24'h000008,
                            B_SUB   = 24'h000004, B_AND     = 24'h000002, B_OR     = 24'h000001;
    localparam logic [23:0] S_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
    localparam logic [23:0] S_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDREAD | B_MDRIN;
    localparam logic [23:0] S_T2 = B_MDROUT | B_IRIN;
    localparam logic [23:0] S_WB = B_ZLOWOUT | B_GRA | B_RIN;

    logic [23:0] strobes;
    assign strobes = {PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC,
                      Read, Write, MD_read, Gra, Grb, Grc, Rin, Rout, BAout, Csignout,
                      ADD, SUB, AND, OR};

    instr_sequencer #(.DATA_W(32), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zlowin(Zlowin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
        .Read(Read), .Write(Write), .MD_read(MD_read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Csignout(Csignout), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .run(run), .illegal_op(illegal_op), .mem_err(mem_err), .state_o(state_o)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        ir = 32'h6000_0000;   // addi
        mem_ready = 1'b1;
        do_clear();
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (state_o !== T4 || strobes !== (B_CSIGN | B_ADD | B_ZLOWIN)) begin
            errors++;
            $display("FAIL reset_pre_t4: state=%0d strobes=%h required state=%0d strobes=%h",
                     state_o, strobes, T4, B_CSIGN | B_ADD | B_ZLOWIN);
        end
        do_clear();
        checks++;
        if (state_o !== T0 || strobes !== S_T0 || run !== 1'b1 || mem_err !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_t0: state=%0d strobes=%h run=%b mem_err=%b ill=%b required state=0 strobes=%h run=1 mem_err=0 ill=0",
                     state_o, strobes, run, mem_err, illegal_op, S_T0);
        end
    endtask

    task automatic test_andi();
        logic [23:0] exp [6];
        exp = '{S_T0, S_T1, S_T2, B_GRB | B_ROUT | B_YIN, B_CSIGN | B_AND | B_ZLOWIN, S_WB};
        ir = 32'h6998_0005;
        mem_ready = 1'b1;
        do_clear();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (state_o !== 5'(k) || strobes !== exp[k]) begin
                errors++;
                $display("FAIL andi_step%0d: state=%0d strobes=%h required state=%0d strobes=%h",
                         k, state_o, strobes, k, exp[k]);
            end
            tick();
        end
        checks++;
        if (state_o !== T0) begin
            errors++;
            $display("FAIL andi_return: state=%0d required %0d", state_o, T0);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] irs [8];
        logic [23:0] t3e [8];
        logic [23:0] t4e [8];
        irs = '{32'h1800_0000, 32'h2000_0000, 32'h2800_0000, 32'h3000_0000,
                32'h6000_0000, 32'h7000_0000, 32'h0800_0000, 32'hD000_0000};
        t3e = '{B_GRB | B_ROUT | B_YIN, B_GRB | B_ROUT | B_YIN, B_GRB | B_ROUT | B_YIN,
                B_GRB | B_ROUT | B_YIN, B_GRB | B_ROUT | B_YIN, B_GRB | B_ROUT | B_YIN,
                B_GRB | B_BAOUT | B_YIN, 24'h0};
        t4e = '{B_GRC | B_ROUT | B_ADD | B_ZLOWIN, B_GRC | B_ROUT | B_SUB | B_ZLOWIN,
                B_GRC | B_ROUT | B_AND | B_ZLOWIN, B_GRC | B_ROUT | B_OR | B_ZLOWIN,
                B_CSIGN | B_ADD | B_ZLOWIN, B_CSIGN | B_OR | B_ZLOWIN,
                B_CSIGN | B_ADD | B_ZLOWIN, 24'h0};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ir = irs[i];
            do_clear();
            for (int k = 0; k < 3; k++) tick();
            checks++;
            if (state_o !== T3 || strobes !== t3e[i] || illegal_op !== 1'b0) begin
                errors++;
                $display("FAIL alu%0d_t3: state=%0d strobes=%h ill=%b required state=3 strobes=%h ill=0",
                         i, state_o, strobes, illegal_op, t3e[i]);
            end
            tick();
            if (i == 7) begin
                checks++;
                if (state_o !== T0) begin
                    errors++;
                    $display("FAIL nop_latency: state=%0d required %0d", state_o, T0);
                end
            end else begin
                checks++;
                if (state_o !== T4 || strobes !== t4e[i]) begin
                    errors++;
                    $display("FAIL alu%0d_t4: state=%0d strobes=%h required state=4 strobes=%h",
                             i, state_o, strobes, t4e[i]);
                end
                tick();
                tick();
                checks++;
                if (state_o !== T0) begin
                    errors++;
                    $display("FAIL alu%0d_latency: state=%0d required %0d", i, state_o, T0);
                end
            end
        end
    endtask

    task automatic test_ld_stall();
        int cycles;
        ir = 32'h0080_0010;
        mem_ready = 1'b1;
        do_clear();
        cycles = 0;
        for (int k = 0; k < 5; k++) begin tick(); cycles++; end
        checks++;
        if (state_o !== T5 || strobes !== (B_ZLOWOUT | B_MARIN)) begin
            errors++;
            $display("FAIL ld_t5: state=%0d strobes=%h required state=5 strobes=%h",
                     state_o, strobes, B_ZLOWOUT | B_MARIN);
        end
        tick(); cycles++;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            checks++;
            if (state_o !== T6 || strobes !== (B_READ | B_MDREAD | B_MDRIN)) begin
                errors++;
                $display("FAIL ld_t6_cyc%0d: state=%0d strobes=%h required state=6 strobes=%h",
                         k, state_o, strobes, B_READ | B_MDREAD | B_MDRIN);
            end
            tick(); cycles++;
        end
        checks++;
        if (state_o !== T7 || strobes !== (B_MDROUT | B_GRA | B_RIN)) begin
            errors++;
            $display("FAIL ld_t7: state=%0d strobes=%h required state=7 strobes=%h",
                     state_o, strobes, B_MDROUT | B_GRA | B_RIN);
        end
        tick(); cycles++;
        checks++;
        if (state_o !== T0 || cycles !== 11) begin
            errors++;
            $display("FAIL ld_total: state=%0d cycles=%0d required state=0 cycles=11", state_o, cycles);
        end
    endtask

    task automatic test_fetch_boundary();
        ir = 32'hD000_0000;
        mem_ready = 1'b1;
        do_clear();
        tick();
        for (int k = 0; k < 15; k++) begin
            mem_ready = (k == 14);
            tick();
        end
        checks++;
        if (state_o !== T2 || mem_err !== 1'b0 || run !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ready_at_limit: state=%0d mem_err=%b run=%b required state=2 mem_err=0 run=1",
                     state_o, mem_err, run);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_st_timeout();
        int stall;
        ir = 32'h1000_0000;
        mem_ready = 1'b1;
        do_clear();
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (state_o !== T6 || strobes !== (B_GRA | B_ROUT | B_MDRIN)) begin
            errors++;
            $display("FAIL st_t6: state=%0d strobes=%h required state=6 strobes=%h",
                     state_o, strobes, B_GRA | B_ROUT | B_MDRIN);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (state_o !== T7 || strobes !== B_WRITE) begin
            errors++;
            $display("FAIL st_t7: state=%0d strobes=%h required state=7 strobes=%h",
                     state_o, strobes, B_WRITE);
        end
        stall = 0;
        while (state_o === T7 && stall < 40) begin
            tick();
            stall++;
        end
        checks++;
        if (stall !== 15 || state_o !== HALT || mem_err !== 1'b1 || run !== 1'b0 || strobes !== 24'h0) begin
            errors++;
            $display("FAIL st_timeout: stall=%0d state=%0d mem_err=%b run=%b strobes=%h required stall=15 state=31 mem_err=1 run=0 strobes=0",
                     stall, state_o, mem_err, run, strobes);
        end
        do_clear();
        checks++;
        if (state_o !== T0 || mem_err !== 1'b0 || run !== 1'b1) begin
            errors++;
            $display("FAIL st_recover: state=%0d mem_err=%b run=%b required state=0 mem_err=0 run=1",
                     state_o, mem_err, run);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        ir = 32'hF800_0000;
        mem_ready = 1'b1;
        do_clear();
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (state_o !== T3 || illegal_op !== 1'b1 || strobes !== 24'h0) begin
            errors++;
            $display("FAIL illegal_t3: state=%0d ill=%b strobes=%h required state=3 ill=1 strobes=0",
                     state_o, illegal_op, strobes);
        end
        tick();
        checks++;
        if (state_o !== T0 || illegal_op !== 1'b0 || strobes !== S_T0) begin
            errors++;
            $display("FAIL illegal_next: state=%0d ill=%b strobes=%h required state=0 ill=0 strobes=%h",
                     state_o, illegal_op, strobes, S_T0);
        end
    endtask

    task automatic test_halt();
        int bad;
        ir = 32'hD800_0000;
        mem_ready = 1'b1;
        do_clear();
        for (int k = 0; k < 4; k++) tick();
        bad = 0;
        for (int k = 0; k < 22; k++) begin
            mem_ready = k[0];
            if (state_o !== HALT || run !== 1'b0 || strobes !== 24'h0 || illegal_op !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL halt_hold: bad_cycles=%0d last state=%0d run=%b strobes=%h required bad_cycles=0 state=31 run=0 strobes=0",
                     bad, state_o, run, strobes);
        end
        do_clear();
        checks++;
        if (state_o !== T0 || run !== 1'b1 || strobes !== S_T0) begin
            errors++;
            $display("FAIL halt_clear: state=%0d run=%b strobes=%h required state=0 run=1 strobes=%h",
                     state_o, run, strobes, S_T0);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        clear = 1'b1;
        ir = 32'h0;
        mem_ready = 1'b1;
        test_reset();
        test_andi();
        test_alu_ops();
        test_ld_stall();
        test_fetch_boundary();
        test_st_timeout();
        test_illegal();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Hardwired control unit that sequences the existing DataPath through fetch, decode and execute. It replaces the hand-timed T0..Tn stimulus currently driven by benches.
- Drives the DataPath control strobes, one micro-step per clock, and stalls on memory accesses until mem_ready.
- Supports load/store, load-immediate, register ALU ops, immediate ALU ops, nop and halt.

Parameters:
- DATA_W, 32, IR width.
- MEM_TIMEOUT, 15, maximum stall cycles per memory access before a fault.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous active-high reset.
- ir  in  DATA_W  IR register contents; opcode is ir[31:27]; ir is valid from T3 onward.
- mem_ready  in  1  memory access complete this cycle.
- PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC  out  1 each  DataPath strobes.
- Read, Write, MD_read  out  1 each  memory/MDR controls.
- Gra, Grb, Grc, Rin, Rout, BAout, Csignout  out  1 each  register-select and immediate controls.
- ADD, SUB, AND, OR  out  1 each  ALU op select; at most one is high.
- run  out  1  high unless halted.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- mem_err  out  1  sticky memory-timeout flag.
- state_o  out  5  current state encoding, for debug.

Behaviour:
- Reset and run
  - clear=1 at a rising edge: state=T0, wait counter=0, mem_err=0, run=1.
  - clear takes effect mid-instruction or mid-stall; the instruction in flight is abandoned.
- Outputs
  - All outputs are Moore decodes of the registered state.
  - In T0 after reset all strobes are 0 except the T0 set.
  - No strobe is ever high outside its listed step.
- Fetch (common to all instructions)
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MD_read, MDRin. Held until mem_ready=1.
  - T2: MDRout, IRin.
  - T3: decode ir[31:27].
- Opcodes and steps
  - Register ALU (add 00011, sub 00100, and 00101, or 00110):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, op, Zlowin.
    - T5: Zlowout, Gra, Rin; then T0.
  - Immediate ALU (addi 01100, andi 01101, ori 01110):
    - T3: Grb, Rout, Yin.
    - T4: Csignout, op, Zlowin.
    - T5: Zlowout, Gra, Rin; then T0.
  - ldi (00001):
    - T3: Grb, BAout, Yin.
    - T4: Csignout, ADD, Zlowin.
    - T5: Zlowout, Gra, Rin; then T0.
  - ld (00000):
    - T3–T4 as ldi.
    - T5: Zlowout, MARin.
    - T6: Read, MD_read, MDRin, held until mem_ready.
    - T7: MDRout, Gra, Rin; then T0.
  - st (00010):
    - T3–T4 as ldi.
    - T5: Zlowout, MARin.
    - T6: Gra, Rout, MDRin, with MD_read=0.
    - T7: Write, held until mem_ready; then T0.
  - nop (11010): T3 asserts nothing; then T0.
  - halt (11011): T3 goes to HALT. In HALT, run=0, all strobes are 0, and the state holds until clear.
  - Any other opcode: treated as nop; illegal_op=1 during that T3 cycle only.
- Memory stalls
  - Applies in T1, ld T6 and st T7.
  - The counter increments each cycle mem_ready=0 and clears on leaving the state.
  - mem_ready=1 in the first cycle of the state means zero stall: exactly one cycle in that state.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1 (sticky) and next state=HALT.
  - If mem_ready=1 arrives in the same cycle the counter hits MEM_TIMEOUT, mem_ready wins and there is no error.
- Latency with no stalls
  - ALU ops, ldi and nop: 6, 6 and 4 cycles respectively.
  - ld and st: 8 cycles each.

Test Plan:
- Reset: assert clear mid-T4 of an addi -> next cycle state_o=T0, PCout=MARin=IncPC=Zlowin=1, every other strobe 0, run=1, mem_err=0.
- andi, ir=0x69980005, mem_ready tied 1 -> exactly 6 cycles T0..T5. T4 asserts exactly Csignout, AND and Zlowin. T5 asserts Zlowout, Gra, Rin. Then back to T0.
- ld, with mem_ready low for 3 cycles in T6 -> T6 lasts 4 cycles with Read, MD_read, MDRin held throughout. T7 asserts MDRout, Gra, Rin. Total 11 cycles.
- st, with mem_ready held 0 in T7 -> after MEM_TIMEOUT=15 stall cycles: mem_err=1, state=HALT, run=0, Write deasserted. clear then restores run=1, mem_err=0.
- opcode 11111 -> illegal_op pulses high for 1 cycle in T3, no strobes in T3, next fetch starts (T0).
- halt -> run=0, outputs frozen at 0 for 20+ cycles regardless of mem_ready; clear -> T0.
